// File: rtl/sqrt_scheduler_if.sv
// Request/result bundle between the requesters and the square-root scheduler.
interface sqrt_scheduler_if;
  logic [3:0]  req;
  logic [31:0] operand;
  logic [3:0]  ack;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        busy;

  modport master (
    output req, operand,
    input  ack, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req, operand,
    output ack, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/sqrt_scheduler.sv
// Round-robin arbiter in front of a bit-serial 8.8 square-root unit shared by four requesters.
//
// state | meaning
// IDLE  | waiting for any req; grants round-robin starting at last_grant+1
// CALC  | 16 cycles, one root bit per cycle from bit 15 down to bit 0
// DONE  | one cycle: res_valid, ack[id], res_data/res_id presented
module sqrt_scheduler (
  input  logic             clk,
  input  logic             rst_n,
  sqrt_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_grant;
  logic [1:0]  grant_idx;
  logic        grant_vld;
  logic [1:0]  cand;
  logic [1:0]  id;
  logic [7:0]  op;
  logic [15:0] root;
  logic [15:0] root_nxt;
  logic [15:0] trial;
  logic [31:0] trial_sq;
  logic [3:0]  bit_cnt;
  logic [15:0] res_data_q;
  logic [1:0]  res_id_q;

  // Walk candidates from the lowest priority (last_grant) up to the highest
  // (last_grant+1) so the last hit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (bus.req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    trial    = root | (16'h0001 << bit_cnt);
    trial_sq = 32'(trial) * 32'(trial);
    root_nxt = (trial_sq <= {op, 16'h0000}) ? trial : root;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b1;
    bus.res_valid = 1'b0;
    bus.ack       = 4'b0000;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (grant_vld) state_nxt = CALC;
      end
      CALC: begin
        if (bit_cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        bus.ack       = 4'b0001 << id;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd3;
      id         <= 2'd0;
      op         <= 8'h00;
      root       <= 16'h0000;
      bit_cnt    <= 4'd0;
      res_data_q <= 16'h0000;
      res_id_q   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op         <= bus.operand[{grant_idx, 3'b000} +: 8];
            id         <= grant_idx;
            last_grant <= grant_idx;
            root       <= 16'h0000;
            bit_cnt    <= 4'd15;
          end
        end
        CALC: begin
          root    <= root_nxt;
          bit_cnt <= bit_cnt - 4'd1;
          // Publish on the final bit so DONE already shows the finished root.
          if (bit_cnt == 4'd0) begin
            res_data_q <= root_nxt;
            res_id_q   <= id;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.res_data = res_data_q;
  assign bus.res_id   = res_id_q;

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler: vector table, arbitration sequences, reset abort and full operand sweep.
module tb_sqrt_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_scheduler_if bus ();

  sqrt_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [7:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_sqrt(input logic [7:0] op);
    longint v, r;
    v = longint'(op) << 16;
    r = longint'($floor($sqrt(real'(v))));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return 16'(r);
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
      check("ack_vs_valid", 32'(bus.ack != 4'b0000), 32'(bus.res_valid));
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.res_valid) ok = 1'b1;
    end
  endtask

  task automatic run_one(input int idx, input logic [7:0] op, input logic [15:0] exp, input string tag);
    int          t0;
    int          busy_n;
    bit          ok;
    logic [31:0] opw;
    opw = $urandom;
    opw[8*idx +: 8] = op;
    bus.operand = opw;
    bus.req     = 4'b0001 << idx;
    t0     = cyc + 1;
    busy_n = 0;
    ok     = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.res_valid) ok = 1'b1;
    end
    if (!ok) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      // Edge count includes the sampling edge itself.
      check({tag, "_latency"}, 32'(cyc - t0 + 1), 32'd17);
      check({tag, "_data"}, 32'(bus.res_data), 32'(exp));
      check({tag, "_id"}, 32'(bus.res_id), 32'(idx));
      check({tag, "_ack"}, 32'(bus.ack), 32'(4'b0001 << idx));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd17);
    end
    bus.req     = 4'b0000;
    bus.operand = $urandom;
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_hold_data"}, 32'(bus.res_data), 32'(exp));
    check({tag, "_hold_id"}, 32'(bus.res_id), 32'(idx));
  endtask

  initial begin
    bit          ok;
    int          last_c;
    logic [15:0] exp4 [4];

    vecs[0] = '{0, 8'd2,   16'h016A};
    vecs[1] = '{0, 8'd0,   16'h0000};
    vecs[2] = '{0, 8'd4,   16'h0200};
    vecs[3] = '{0, 8'd255, 16'h0FF7};
    vecs[4] = '{1, 8'd1,   16'h0100};
    vecs[5] = '{2, 8'd9,   16'h0300};
    vecs[6] = '{3, 8'd16,  16'h0400};
    vecs[7] = '{1, 8'd100, 16'h0A00};
    vecs[8] = '{3, 8'd255, 16'h0FF7};
    vecs[9] = '{2, 8'd2,   16'h016A};

    bus.req     = 4'b0000;
    bus.operand = 32'h0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data", 32'(bus.res_data), 32'h0);
    check("rst_id", 32'(bus.res_id), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("noreq_busy", 32'(bus.busy), 32'd0);
    end

    for (int v = 0; v < 10; v++)
      run_one(vecs[v].idx, vecs[v].op, vecs[v].exp, $sformatf("vec%0d", v));

    // Request withdrawn and operand trashed right after grant.
    bus.req     = 4'b0010;
    bus.operand = 32'h0000_0900;
    @(posedge clk);
    #1;
    bus.req     = 4'b0000;
    bus.operand = 32'hFFFF_FFFF;
    wait_valid(ok);
    check("ignore_after_grant_seen", 32'(ok), 32'd1);
    check("ignore_after_grant_data", 32'(bus.res_data), 32'h0300);
    check("ignore_after_grant_id", 32'(bus.res_id), 32'd1);
    check("ignore_after_grant_ack", 32'(bus.ack), 32'b0010);
    @(negedge clk);

    // Reset in the 8th CALC cycle aborts the operation.
    bus.req     = 4'b0001;
    bus.operand = 32'h0000_00C8;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ack", 32'(bus.ack), 32'd0);
    check("abort_valid", 32'(bus.res_valid), 32'd0);
    check("abort_data", 32'(bus.res_data), 32'h0);
    check("abort_id", 32'(bus.res_id), 32'd0);
    bus.req = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_valid", 32'(bus.res_valid), 32'd0);
    end
    rst_n       = 1'b1;
    bus.req     = 4'b1001;
    bus.operand = 32'h0900_0004;
    wait_valid(ok);
    check("post_abort_first_seen", 32'(ok), 32'd1);
    check("post_abort_first_id", 32'(bus.res_id), 32'd0);
    check("post_abort_first_data", 32'(bus.res_data), 32'h0200);
    bus.req[0] = 1'b0;
    wait_valid(ok);
    check("post_abort_second_seen", 32'(ok), 32'd1);
    check("post_abort_second_id", 32'(bus.res_id), 32'd3);
    check("post_abort_second_data", 32'(bus.res_data), 32'h0300);
    bus.req = 4'b0000;
    @(negedge clk);

    // All four requesting after reset: strict rotation, 18-cycle ack spacing.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    exp4        = '{16'h0100, 16'h0300, 16'h0400, 16'h0A00};
    bus.operand = 32'h6410_0901;
    bus.req     = 4'b1111;
    last_c      = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      if (!ok) begin
        check($sformatf("rr4_timeout%0d", k), 32'd0, 32'd1);
        break;
      end
      check($sformatf("rr4_id%0d", k), 32'(bus.res_id), 32'(k));
      check($sformatf("rr4_data%0d", k), 32'(bus.res_data), 32'(exp4[k]));
      check($sformatf("rr4_ack%0d", k), 32'(bus.ack), 32'(4'b0001 << k));
      if (k > 0) check($sformatf("rr4_gap%0d", k), 32'(cyc - last_c), 32'd18);
      last_c = cyc;
      bus.req[bus.res_id] = 1'b0;
    end
    bus.req = 4'b0000;
    @(negedge clk);

    // Requester 1 just served: requester 2 outranks requester 0.
    run_one(1, 8'd49, 16'h0700, "rr_prep");
    bus.operand = 32'h0024_0019;
    bus.req     = 4'b0101;
    wait_valid(ok);
    check("rr_first_seen", 32'(ok), 32'd1);
    check("rr_first_id", 32'(bus.res_id), 32'd2);
    check("rr_first_data", 32'(bus.res_data), 32'h0600);
    bus.req[2] = 1'b0;
    wait_valid(ok);
    check("rr_second_seen", 32'(ok), 32'd1);
    check("rr_second_id", 32'(bus.res_id), 32'd0);
    check("rr_second_data", 32'(bus.res_data), 32'h0500);
    bus.req = 4'b0000;
    @(negedge clk);

    for (int idx = 0; idx < 4; idx++)
      for (int op = 0; op < 256; op++)
        run_one(idx, 8'(op), ref_sqrt(8'(op)), $sformatf("sweep_r%0d_op%0d", idx, op));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
